// File: rtl/rsa_modexp_pkg.sv
// Shared definitions for the modular-exponentiation engine: FSM state
// encodings and the fixed modular-multiply latency. The testbench reuses them.
package rsa_modexp_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StSqr  = 3'd2,
        StMul  = 3'd3,
        StNext = 3'd4,
        StFin  = 3'd5
    } state_e;

    // Cycles per modular multiply: 1 start, one per operand bit, 1 writeback.
    function automatic int unsigned mm_lat(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: P = A*B mod N, MSB first.
// A pulse on go latches the operands; ready pulses with P valid after a
// fixed mm_lat(WIDTH) cycles counted from the go cycle inclusive.
// Requires B < N so the partial product stays below 3N.
module rsa_modmul
    import rsa_modexp_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] P,
    output logic             ready
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             run_q, run_d, ready_q, ready_d;
    logic [WIDTH+1:0] n_ext, p_acc, p_sub1;
    logic [WIDTH-1:0] p_step;

    // One iteration: P = 2P + A[j]*B, then up to two subtractions of N.
    always_comb begin
        n_ext  = {2'b00, n_q};
        p_acc  = {1'b0, p_q, 1'b0} + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        p_sub1 = (p_acc >= n_ext) ? (p_acc - n_ext) : p_acc;
        // p_sub1 < 2N here, so the low WIDTH bits suffice for the final step
        p_step = (p_sub1 >= n_ext) ? (p_sub1[WIDTH-1:0] - n_q) : p_sub1[WIDTH-1:0];
    end

    // Next-state: load on go, iterate while running, pulse ready at the end.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        ready_d = 1'b0;
        if (go) begin
            a_d   = A;
            b_d   = B;
            n_d   = N;
            p_d   = '0;
            cnt_d = CntW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            p_d = p_step;
            if (cnt_q == '0) begin
                run_d   = 1'b0;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            ready_q <= ready_d;
        end
    end

    assign P     = p_q;
    assign ready = ready_q;

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation Result = Data^Key mod N, left-to-right
// square-and-multiply over all KEY_W key bits (no leading-zero skip, so the
// latency depends only on popcount(Key)). One rsa_modmul is time-shared
// between squaring and multiplying.
// Optional feature macro RSA_ARG_CHECK_EN: adds the Error port and rejects
// N < 2 or Data >= N with Result = 0 after a two-cycle latency.
module rsa_modexp
    import rsa_modexp_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned KEY_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [KEY_W-1:0] Key,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy
`ifdef RSA_ARG_CHECK_EN
    ,
    output logic             Error
`endif
);

    localparam int unsigned IdxW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, n_q, n_d, result_q, result_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             mm_go, mm_ready;
    logic [WIDTH-1:0] mm_b, mm_p;
`ifdef RSA_ARG_CHECK_EN
    logic             err_q, err_d;
`endif

    // pend_q marks a multiply in flight so each SQR/MUL issues go only once.
    // NEXT starts the following square itself, which keeps every step at
    // exactly mm_lat cycles including the bit bookkeeping.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        n_d      = n_q;
        key_d    = key_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        result_d = result_q;
        mm_go    = 1'b0;
        mm_b     = acc_q;
`ifdef RSA_ARG_CHECK_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    base_d  = Data;
                    key_d   = Key;
                    n_d     = N;
                    state_d = StLoad;
`ifdef RSA_ARG_CHECK_EN
                    err_d   = (N < WIDTH'(2)) || (Data >= N);
`endif
                end
            end
            StLoad: begin
                acc_d   = WIDTH'(1);
                idx_d   = IdxW'(KEY_W - 1);
                pend_d  = 1'b0;
                state_d = StSqr;
`ifdef RSA_ARG_CHECK_EN
                // Bad operands: fall straight through NEXT (index 0) to FIN
                if (err_q) begin
                    idx_d   = '0;
                    state_d = StNext;
                end
`endif
            end
            StSqr: begin
                if (!pend_q) begin
                    mm_go  = 1'b1;
                    pend_d = 1'b1;
                end else if (mm_ready) begin
                    acc_d   = mm_p;
                    pend_d  = 1'b0;
                    state_d = key_q[idx_q] ? StMul : StNext;
                end
            end
            StMul: begin
                mm_b = base_q;
                if (!pend_q) begin
                    mm_go  = 1'b1;
                    pend_d = 1'b1;
                end else if (mm_ready) begin
                    acc_d   = mm_p;
                    pend_d  = 1'b0;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == '0) begin
                    result_d = acc_q;
`ifdef RSA_ARG_CHECK_EN
                    if (err_q) begin
                        result_d = '0;
                    end
`endif
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q - IdxW'(1);
                    mm_go   = 1'b1;
                    pend_d  = 1'b1;
                    state_d = StSqr;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Engine state and operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            base_q   <= '0;
            n_q      <= '0;
            key_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            result_q <= '0;
`ifdef RSA_ARG_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            n_q      <= n_d;
            key_q    <= key_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            result_q <= result_d;
`ifdef RSA_ARG_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    rsa_modmul #(
        .WIDTH(WIDTH)
    ) u_modmul (
        .clk  (clk),
        .reset(reset),
        .go   (mm_go),
        .A    (acc_q),
        .B    (mm_b),
        .N    (n_q),
        .P    (mm_p),
        .ready(mm_ready)
    );

    assign Result = result_q;
    assign Done   = (state_q == StFin);
    assign Busy   = (state_q != StIdle);
`ifdef RSA_ARG_CHECK_EN
    assign Error  = (state_q == StFin) && err_q;
`endif

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed testbench for rsa_modexp with hand-computed expected results and
// latencies (latency = 2 + (KEY_W + popcount(Key)) * mm_lat(WIDTH)).
module tb_rsa_modexp;
    import rsa_modexp_pkg::*;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned KEY_W = 6;
    localparam int MmLat = int'(mm_lat(WIDTH));

    logic             clk;
    logic             reset;
    logic             Start;
    logic [WIDTH-1:0] Data;
    logic [KEY_W-1:0] Key;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] Result;
    logic             Done;
    logic             Busy;
`ifdef RSA_ARG_CHECK_EN
    logic             Error;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rsa_modexp #(
        .WIDTH(WIDTH),
        .KEY_W(KEY_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .Data  (Data),
        .Key   (Key),
        .N     (N),
        .Result(Result),
        .Done  (Done),
        .Busy  (Busy)
`ifdef RSA_ARG_CHECK_EN
        ,
        .Error (Error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [KEY_W-1:0] k);
        return 2 + (int'(KEY_W) + $countones(k)) * MmLat;
    endfunction

    // Issue one operation; inject_at > 0 re-pulses Start (with other operands)
    // at that cycle of the run; on_done pulses Start in the Done cycle.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [KEY_W-1:0] k,
                          input logic [WIDTH-1:0] n, input int inject_at, input bit on_done,
                          output logic [WIDTH-1:0] res, output int lat, output bit busy_ok,
                          output bit err_seen);
        Data  = d;
        Key   = k;
        N     = n;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        lat      = -1;
        busy_ok  = 1'b1;
        res      = '0;
        err_seen = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == inject_at) begin
                Start = 1'b1;
                Data  = 5;
                Key   = 1;
                N     = 7;
            end else if (cyc == inject_at + 1) begin
                Start = 1'b0;
            end
            if (!Busy) busy_ok = 1'b0;
            if (Done) begin
                lat = cyc;
                res = Result;
`ifdef RSA_ARG_CHECK_EN
                err_seen = Error;
`endif
                break;
            end
        end
        if (on_done) begin
            Start = 1'b1;
            Data  = 1;
            Key   = 1;
            N     = 3;
        end
        @(posedge clk);
        #1;
        Start = 1'b0;
        check_eq("done_single_pulse", 32'(Done), 32'd0);
        check_eq("busy_low_after_done", 32'(Busy), 32'd0);
    endtask

    task automatic vec(input string tag, input logic [WIDTH-1:0] d, input logic [KEY_W-1:0] k,
                       input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] exp_res,
                       input int inject_at, input bit on_done);
        logic [WIDTH-1:0] res;
        int               lat;
        bit               busy_ok;
        bit               err_seen;
        run_op(d, k, n, inject_at, on_done, res, lat, busy_ok, err_seen);
        check_eq({tag, "_result"}, 32'(res), 32'(exp_res));
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat(k)));
        check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_error"}, 32'(err_seen), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        int               lat;
        bit               busy_ok;
        bit               err_seen;

        reset = 1'b1;
        Start = 1'b0;
        Data  = '0;
        Key   = '0;
        N     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_result", 32'(Result), 32'd0);
        check_eq("reset_done", 32'(Done), 32'd0);
        check_eq("reset_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        vec("s1_4pow7_mod33", 6'd4, 6'd7, 6'd33, 6'd16, 0, 1'b0);
        vec("s2_16pow3_mod33", 6'd16, 6'd3, 6'd33, 6'd4, 0, 1'b0);
        vec("s3_62pow63_mod63", 6'd62, 6'd63, 6'd63, 6'd62, 0, 1'b0);
        vec("s3_key0", 6'd5, 6'd0, 6'd63, 6'd1, 0, 1'b0);
        vec("s3_data0", 6'd0, 6'd5, 6'd63, 6'd0, 0, 1'b0);
        vec("2pow10_mod61", 6'd2, 6'd10, 6'd61, 6'd48, 0, 1'b0);
        vec("3pow5_mod35", 6'd3, 6'd5, 6'd35, 6'd33, 0, 1'b0);
        vec("n2_1pow63", 6'd1, 6'd63, 6'd2, 6'd1, 0, 1'b0);
        vec("s4_start_while_busy", 6'd4, 6'd7, 6'd33, 6'd16, 10, 1'b0);
        vec("start_in_done_cycle", 6'd16, 6'd3, 6'd33, 6'd4, 0, 1'b1);

        // Reset in the middle of a run aborts it; Result was 4 beforehand.
        Data  = 6'd4;
        Key   = 6'd7;
        N     = 6'd33;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("s5_reset_busy", 32'(Busy), 32'd0);
        check_eq("s5_reset_done", 32'(Done), 32'd0);
        check_eq("s5_reset_result", 32'(Result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec("s5_after_reset", 6'd16, 6'd3, 6'd33, 6'd4, 0, 1'b0);

`ifdef RSA_ARG_CHECK_EN
        run_op(6'd0, 6'd3, 6'd1, 0, 1'b0, res, lat, busy_ok, err_seen);
        check_eq("s6_n1_result", 32'(res), 32'd0);
        check_eq("s6_n1_latency", 32'(lat), 32'd2);
        check_eq("s6_n1_error", 32'(err_seen), 32'd1);
        run_op(6'd40, 6'd7, 6'd33, 0, 1'b0, res, lat, busy_ok, err_seen);
        check_eq("s6_data40_result", 32'(res), 32'd0);
        check_eq("s6_data40_latency", 32'(lat), 32'd2);
        check_eq("s6_data40_error", 32'(err_seen), 32'd1);
`else
        // Out-of-range Data still completes with the normal latency.
        run_op(6'd40, 6'd7, 6'd33, 0, 1'b0, res, lat, busy_ok, err_seen);
        check_eq("unchecked_latency", 32'(lat), 32'(exp_lat(6'd7)));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
